// File: rtl/ebpc_merger.sv
// ebpc_merger: merges the ZRLE flag stream with BPC values into the original data stream,
// then drops the padding values that complete the frame's final BPC block.
module ebpc_merger #(
  parameter int DATA_W     = 8,
  parameter int BLOCK_SIZE = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flag_i,
  input  logic              flag_last_i,
  input  logic              flag_vld_i,
  output logic              flag_rdy_o,
  input  logic [DATA_W-1:0] bpc_data_i,
  input  logic              bpc_last_i,
  input  logic              bpc_vld_i,
  output logic              bpc_rdy_o,
  output logic [DATA_W-1:0] data_o,
  output logic              last_o,
  output logic              vld_o,
  input  logic              rdy_i,
  output logic              idle_o,
  output logic              err_o
);
  localparam int CW = $clog2(BLOCK_SIZE);
  typedef enum logic {RUN, DRAIN} state_e;
  state_e        state_q, state_d;
  logic [CW-1:0] nz_cnt_q, nz_n, exp_pad_q;
  logic [CW:0]   pad_cnt_q;
  logic          in_frame_q, has_nz_q, bpc_done_q;
  logic          slot_free, f_acc, b_acc, end_frame, drain, err_d;
  assign slot_free  = !vld_o || rdy_i;
  assign flag_rdy_o = (state_q == RUN) && slot_free && (!flag_i || bpc_vld_i);
  assign bpc_rdy_o  = (state_q == DRAIN) || (flag_vld_i && flag_i && bpc_vld_i && slot_free);
  assign f_acc      = flag_vld_i && flag_rdy_o;
  assign b_acc      = bpc_vld_i && bpc_rdy_o;
  assign nz_n       = nz_cnt_q + CW'(flag_i);
  assign end_frame  = f_acc && flag_last_i;
  // A frame whose BPC stream already ended (even early) never drains.
  assign drain      = end_frame && (has_nz_q || flag_i) && !(bpc_done_q || (flag_i && bpc_last_i));
  assign idle_o     = (state_q == RUN) && !in_frame_q && !vld_o;
  always_comb begin
    state_d = state_q == RUN ? (drain ? DRAIN : RUN) : ((b_acc && bpc_last_i) ? RUN : DRAIN);
    err_d   = state_q == RUN
            ? (f_acc && flag_i && bpc_last_i && (!flag_last_i || nz_n != '0))
            : (b_acc && bpc_last_i && (pad_cnt_q + 1'b1 != {1'b0, exp_pad_q}));
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= RUN;
      data_o     <= '0;
      last_o     <= 1'b0;
      vld_o      <= 1'b0;
      err_o      <= 1'b0;
      nz_cnt_q   <= '0;
      exp_pad_q  <= '0;
      pad_cnt_q  <= '0;
      in_frame_q <= 1'b0;
      has_nz_q   <= 1'b0;
      bpc_done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      err_o   <= err_d;
      if (f_acc) begin
        data_o     <= flag_i ? bpc_data_i : '0;
        last_o     <= flag_last_i;
        vld_o      <= 1'b1;
        nz_cnt_q   <= flag_last_i ? '0 : nz_n;
        in_frame_q <= !flag_last_i;
        has_nz_q   <= !flag_last_i && (has_nz_q || flag_i);
        bpc_done_q <= !flag_last_i && (bpc_done_q || (flag_i && bpc_last_i));
      end else if (rdy_i) begin
        vld_o <= 1'b0;
      end
      if (drain) begin
        pad_cnt_q <= '0;
        exp_pad_q <= -nz_n;
      end else if (state_q == DRAIN && b_acc) begin
        pad_cnt_q <= pad_cnt_q + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_ebpc_merger.sv
// tb_ebpc_merger: randomized scoreboard bench; frames are expanded into flag, BPC and
// expected-output streams from the encoder's block-padding rule.
module tb_ebpc_merger;
  localparam int DW = 8;
  localparam int BS = 8;
  logic          clk_i = 1'b0, rst_ni = 1'b0;
  logic          flag_i = 1'b0, flag_last_i = 1'b0, flag_vld_i = 1'b0, flag_rdy_o;
  logic [DW-1:0] bpc_data_i = '0;
  logic          bpc_last_i = 1'b0, bpc_vld_i = 1'b0, bpc_rdy_o;
  logic [DW-1:0] data_o;
  logic          last_o, vld_o, rdy_i = 1'b1, idle_o, err_o;

  ebpc_merger #(.DATA_W(DW), .BLOCK_SIZE(BS)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .flag_i(flag_i), .flag_last_i(flag_last_i), .flag_vld_i(flag_vld_i), .flag_rdy_o(flag_rdy_o),
    .bpc_data_i(bpc_data_i), .bpc_last_i(bpc_last_i), .bpc_vld_i(bpc_vld_i), .bpc_rdy_o(bpc_rdy_o),
    .data_o(data_o), .last_o(last_o), .vld_o(vld_o), .rdy_i(rdy_i),
    .idle_o(idle_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { bit f; bit last; int gap; } flag_t;
  typedef struct { logic [DW-1:0] d; bit last; int gap; } bpc_t;
  typedef struct { logic [DW-1:0] d; bit last; } exp_t;
  typedef bit            bits_t[$];
  typedef logic [DW-1:0] vals_t[$];

  flag_t flag_q[$];
  bpc_t  bpc_q[$];
  exp_t  exp_q[$];
  int    checks = 0, passes = 0, exp_err = 0, err_seen = 0, max_gap = 0, rdy_mode = 0;
  int    bpc_rdy_seen = 0;
  bit    watch_bpc = 0, hold = 0;
  logic [DW:0] held;

  task automatic chk(input string name, input longint act, input longint want);
    checks++;
    if (act == want) passes++;
    else $display("FAIL %s: got %0h want %0h", name, act, want);
  endtask

  // Expand a frame: zero flags emit 0, non-zero flags emit the next value; BPC words are
  // padded with zeros up to a whole number of blocks, last on the final word.
  task automatic add_frame(input bits_t fl, input vals_t vals);
    int nz = 0, nb;
    for (int i = 0; i < fl.size(); i++) begin
      flag_q.push_back('{fl[i], i == fl.size() - 1, $urandom_range(0, max_gap)});
      exp_q.push_back('{fl[i] ? vals[nz] : '0, i == fl.size() - 1});
      if (fl[i]) nz++;
    end
    nb = ((nz + BS - 1) / BS) * BS;
    for (int j = 0; j < nb; j++)
      bpc_q.push_back('{j < nz ? vals[j] : '0, j == nb - 1, $urandom_range(0, max_gap)});
    if (nz > 0 && nz % BS == 0 && !fl[fl.size() - 1]) exp_err++;
  endtask

  task automatic rand_frame();
    bits_t fl;
    vals_t v;
    int len = $urandom_range(1, 20);
    for (int i = 0; i < len; i++) begin
      fl.push_back($urandom_range(0, 3) != 0);
      if (fl[i]) v.push_back(DW'($urandom_range(1, 255)));
    end
    add_frame(fl, v);
  endtask

  task automatic wait_idle(input string name);
    int t = 0;
    while ((flag_q.size() || bpc_q.size() || exp_q.size() || flag_vld_i || bpc_vld_i || !idle_o) && t < 3000) begin
      @(negedge clk_i);
      t++;
    end
    chk(name, t < 3000, 1);
  endtask

  initial begin
    flag_t f;
    bit ok;
    int t;
    @(posedge clk_i); #1;
    forever begin
      if (flag_q.size() == 0) begin
        @(posedge clk_i); #1;
      end else begin
        f = flag_q.pop_front();
        repeat (f.gap) begin @(posedge clk_i); #1; end
        {flag_vld_i, flag_i, flag_last_i} = {1'b1, f.f, f.last};
        t = 0;
        do begin
          @(negedge clk_i); ok = flag_rdy_o;
          @(posedge clk_i); #1; t++;
        end while (!ok && t < 200);
        if (!ok) chk("flag_timeout", t, 0);
        flag_vld_i = 1'b0;
      end
    end
  end

  initial begin
    bpc_t b;
    bit ok;
    int t;
    @(posedge clk_i); #1;
    forever begin
      if (bpc_q.size() == 0) begin
        @(posedge clk_i); #1;
      end else begin
        b = bpc_q.pop_front();
        repeat (b.gap) begin @(posedge clk_i); #1; end
        {bpc_vld_i, bpc_data_i, bpc_last_i} = {1'b1, b.d, b.last};
        t = 0;
        do begin
          @(negedge clk_i); ok = bpc_rdy_o;
          @(posedge clk_i); #1; t++;
        end while (!ok && t < 200);
        if (!ok) chk("bpc_timeout", t, 0);
        bpc_vld_i = 1'b0;
      end
    end
  end

  initial forever begin
    @(posedge clk_i); #1;
    rdy_i = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? ~rdy_i : 1'($urandom_range(0, 1));
  end

  always @(negedge clk_i) if (rst_ni) begin
    exp_t e;
    if (err_o) err_seen++;
    if (watch_bpc && bpc_rdy_o) bpc_rdy_seen++;
    if (hold) chk("hold_data", {vld_o, last_o, data_o}, {1'b1, held});
    if (vld_o && !rdy_i) chk("flag_rdy_full", flag_rdy_o, 0);
    if (flag_vld_i && flag_i && !bpc_vld_i) chk("nz_wait_bpc", flag_rdy_o, 0);
    if (vld_o && rdy_i) begin
      if (exp_q.size() == 0) chk("unexpected_out", {last_o, data_o}, 1'bx);
      else begin
        e = exp_q.pop_front();
        chk("out_data", data_o, e.d);
        chk("out_last", last_o, e.last);
      end
    end
    hold = vld_o && !rdy_i;
    held = {last_o, data_o};
  end

  initial begin
    bits_t fl;
    vals_t v;
    int t;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_vld", vld_o, 0);
    chk("rst_data", data_o, 0);
    chk("rst_last", last_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_idle", idle_o, 1);
    @(posedge clk_i); #1 rst_ni = 1'b1;

    fl = '{0, 1, 0, 1}; v = '{8'h11, 8'h22};
    add_frame(fl, v);
    wait_idle("t1_done");
    chk("t1_err", err_seen, 0);

    fl = '{1, 1, 1, 1, 1, 1, 1, 1}; v = '{1, 2, 3, 4, 5, 6, 7, 8};
    add_frame(fl, v);
    wait_idle("t2_done");
    chk("t2_err", err_seen, 0);

    watch_bpc = 1;
    fl = '{0, 0, 0, 0, 0}; v = '{};
    add_frame(fl, v);
    wait_idle("t3_done");
    watch_bpc = 0;
    chk("t3_bpc_rdy", bpc_rdy_seen, 0);

    rdy_mode = 1;
    fl = '{1, 1, 1, 0, 1}; v = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    add_frame(fl, v);
    wait_idle("t4_done");
    rdy_mode = 0;

    fl = '{1, 0, 0}; v = '{8'h77};
    add_frame(fl, v);
    bpc_q[0].gap = 4;
    wait_idle("t5_done");

    flag_q.push_back('{1, 0, 0}); flag_q.push_back('{1, 0, 0});
    flag_q.push_back('{0, 0, 0}); flag_q.push_back('{0, 1, 0});
    bpc_q.push_back('{8'hAA, 0, 0}); bpc_q.push_back('{8'hBB, 1, 0});
    exp_q.push_back('{8'hAA, 0}); exp_q.push_back('{8'hBB, 0});
    exp_q.push_back('{8'h00, 0}); exp_q.push_back('{8'h00, 1});
    exp_err++;
    wait_idle("t6_done");
    chk("t6_err", err_seen, exp_err);
    fl = '{0, 1, 1, 0, 1}; v = '{8'h31, 8'h32, 8'h33};
    add_frame(fl, v);
    wait_idle("t6_next");
    chk("t6_next_err", err_seen, exp_err);

    fl = '{1, 1, 1, 1, 1, 1, 1, 1, 0}; v = '{9, 8, 7, 6, 5, 4, 3, 2};
    add_frame(fl, v);
    wait_idle("full_block_zero_tail");

    max_gap = 3; rdy_mode = 2;
    repeat (40) rand_frame();
    wait_idle("rand_done");
    chk("rand_err", err_seen, exp_err);
    max_gap = 0; rdy_mode = 0;

    flag_q.push_back('{0, 0, 0}); flag_q.push_back('{1, 1, 0});
    bpc_q.push_back('{8'h5A, 0, 0});
    exp_q.push_back('{8'h00, 0}); exp_q.push_back('{8'h5A, 1});
    t = 0;
    while ((flag_q.size() || bpc_q.size() || exp_q.size() || flag_vld_i || bpc_vld_i) && t < 500) begin
      @(negedge clk_i); t++;
    end
    chk("drain_reach", t < 500, 1);
    repeat (2) @(negedge clk_i);
    chk("drain_busy", idle_o, 0);
    chk("drain_bpc_rdy", bpc_rdy_o, 1);
    @(posedge clk_i); #1 rst_ni = 1'b0;
    @(negedge clk_i);
    chk("mrst_vld", vld_o, 0);
    chk("mrst_data", data_o, 0);
    chk("mrst_err", err_o, 0);
    chk("mrst_bpc_rdy", bpc_rdy_o, 0);
    @(posedge clk_i); #1 rst_ni = 1'b1;
    @(negedge clk_i);
    chk("mrst_idle", idle_o, 1);
    fl = '{1, 0, 1}; v = '{8'hC1, 8'hC2};
    add_frame(fl, v);
    wait_idle("post_rst");
    chk("final_err", err_seen, exp_err);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
